// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end over a word-addressed memory with a registered read port.
// Sub-word stores are read-modify-write; misaligned or illegal-size requests complete at once with resp_err.
module load_store_unit #(
  parameter int addresswidth = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [addresswidth-1:0] req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_read_en,
  output logic                    mem_write_en,
  output logic [31:0]             mem_data_in,
  input  logic [31:0]             mem_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_LD, S_WR} state_t;

  state_t                  state_q;
  logic                    write_q;
  logic [1:0]              size_q;
  logic                    signed_q;
  logic [addresswidth-1:0] addr_q;
  logic [15:0]             wdata_q;
  logic [31:0]             wbuf_q;
  logic                    resp_valid_q;
  logic                    resp_err_q;
  logic [31:0]             resp_rdata_q;

  logic        req_misalign;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext;
  logic [31:0] mask;
  logic [31:0] ins;
  logic [31:0] merged;

  assign req_misalign = (req_size == 2'b11) ||
                        ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Memory side depends only on state and latched fields, never on live request inputs.
  assign req_ready    = (state_q == S_IDLE);
  assign mem_read_en  = (state_q == S_RD);
  assign mem_write_en = (state_q == S_WR);
  assign mem_address  = {2'b00, addr_q[addresswidth-1:2]};
  assign mem_data_in  = wbuf_q;

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  always_comb begin
    lane_b = 8'h00;
    lane_h = 16'h0000;
    ld_ext = mem_data_out;
    mask   = 32'h0000_0000;
    ins    = 32'h0000_0000;
    case (addr_q[1:0])
      2'b00:   lane_b = mem_data_out[7:0];
      2'b01:   lane_b = mem_data_out[15:8];
      2'b10:   lane_b = mem_data_out[23:16];
      default: lane_b = mem_data_out[31:24];
    endcase
    lane_h = addr_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (size_q)
      2'b00:   ld_ext = signed_q ? {{24{lane_b[7]}}, lane_b} : {24'h000000, lane_b};
      2'b01:   ld_ext = signed_q ? {{16{lane_h[15]}}, lane_h} : {16'h0000, lane_h};
      default: ld_ext = mem_data_out;
    endcase
    if (size_q == 2'b00) begin
      mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      ins  = {4{wdata_q[7:0]}};
    end else begin
      mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      ins  = {2{wdata_q}};
    end
    merged = (mem_data_out & ~mask) | (ins & mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 16'h0000;
      wbuf_q       <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata[15:0];
            if (req_misalign) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0000_0000;
            end else if (req_write && (req_size == 2'b10)) begin
              wbuf_q  <= req_wdata;
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: state_q <= S_LD;
        S_LD: begin
          if (write_q) begin
            wbuf_q  <= merged;
            state_q <= S_WR;
          end else begin
            resp_rdata_q <= ld_ext;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_WR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0000_0000;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  load_store_unit #(.addresswidth(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Word memory: write on posedge, read data registered and only valid the cycle after read_en.
  logic [31:0] mem_model [64];
  logic [31:0] rd_q;
  logic        rd_vld_q = 1'b0;
  always @(posedge clk) begin
    rd_vld_q <= mem_read_en;
    if (mem_address < 32'd64) begin
      if (mem_write_en) mem_model[mem_address[5:0]] <= mem_data_in;
      if (mem_read_en)  rd_q <= mem_model[mem_address[5:0]];
    end
  end
  assign mem_data_out = rd_vld_q ? rd_q : 32'hzzzz_zzzz;

  int rd_cnt = 0;
  int wr_cnt = 0;
  int ov_cnt = 0;
  always @(negedge clk) begin
    if (mem_read_en)                 rd_cnt <= rd_cnt + 1;
    if (mem_write_en)                wr_cnt <= wr_cnt + 1;
    if (mem_read_en && mem_write_en) ov_cnt <= ov_cnt + 1;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  task automatic do_req(input vec_t v, input string tag);
    int lat;
    int rd0;
    int wr0;
    bit got;
    @(negedge clk);
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_valid  = 1'b1;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 8) begin
      if (resp_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1 lat++;
      end
    end
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, " err"}, {31'b0, resp_err}, {31'b0, v.exp_err});
    @(negedge clk);
    chk({tag, " read pulses"}, rd_cnt - rd0, v.exp_rd);
    chk({tag, " write pulses"}, wr_cnt - wr0, v.exp_wr);
  endtask

  vec_t vecs[$];
  int   resp_cyc[$];

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    // wr, size, sgn, addr, wdata, exp_rdata, exp_err, lat, reads, writes
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 32'h0,        1'b0, 2, 0, 1});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h23, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h23, 32'h0,        32'h00000080, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h20, 32'h0,        32'h00000001, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        32'h0000007F, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'h00007F01, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'hFFFF80FF, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h20, 32'hAABBCCDD, 32'h0,        1'b0, 2, 0, 1});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234, 32'h0,        1'b0, 4, 1, 1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h1234CCDD, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'h00001234, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'hFFFFCCDD, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h30, 32'h00000000, 32'h0,        1'b0, 2, 0, 1});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h31, 32'h1234565A, 32'h0,        1'b0, 4, 1, 1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h30, 32'h0,        32'h00005A00, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h02, 32'h0,        32'h0,        1'b1, 1, 0, 0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h13, 32'h0000FFFF, 32'h0,        1'b1, 1, 0, 0});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h14, 32'hCAFEF00D, 32'h0,        1'b1, 1, 0, 0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'h0,        1'b0, 2, 0, 1});

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready",    {31'b0, req_ready},    32'd1);
    chk("reset resp_valid",   {31'b0, resp_valid},   32'd0);
    chk("reset resp_err",     {31'b0, resp_err},     32'd0);
    chk("reset resp_rdata",   resp_rdata,            32'h0);
    chk("reset mem_read_en",  {31'b0, mem_read_en},  32'd0);
    chk("reset mem_write_en", {31'b0, mem_write_en}, 32'd0);
    chk("reset mem_address",  mem_address,           32'h0);
    chk("reset mem_data_in",  mem_data_in,           32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) do_req(vecs[i], $sformatf("vec%0d", i));

    chk("sw word index 4", mem_model[4], 32'hDEADBEEF);
    chk("read/write overlap", ov_cnt, 32'd0);

    // Back-to-back word stores with req_valid held high.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h50; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
    for (int c = 1; c <= 12 && resp_cyc.size() < 3; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) resp_cyc.push_back(c);
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk("b2b response count", resp_cyc.size(), 32'd3);
    if (resp_cyc.size() == 3) begin
      chk("b2b gap 1", resp_cyc[1] - resp_cyc[0], 32'd2);
      chk("b2b gap 2", resp_cyc[2] - resp_cyc[1], 32'd2);
    end
    chk("b2b stored word", mem_model[20], 32'h0BADF00D);

    // Reset while a sub-word store sits in WR.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_addr = 32'h40;
    req_wdata = 32'h00000077; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midop in WR", {31'b0, mem_write_en}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midop write_en",   {31'b0, mem_write_en}, 32'd0);
    chk("midop read_en",    {31'b0, mem_read_en},  32'd0);
    chk("midop req_ready",  {31'b0, req_ready},    32'd1);
    chk("midop resp_valid", {31'b0, resp_valid},   32'd0);
    chk("midop mem_data_in", mem_data_in,          32'h0);
    chk("midop mem_address", mem_address,          32'h0);
    @(posedge clk);
    #1;
    chk("midop memory untouched", mem_model[16], 32'h11223344);
    chk("midop no response", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_req('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h11223344, 1'b0, 3, 1, 0}, "post-reset lw");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
